// File: rtl/svm_pkg.sv
// ============================================================================
// Module   : svm_pkg
// Brief    : Shared constants, pair-count helper and FSM state set for the OvO SVM.
// Revision : 1.0
// ============================================================================
`default_nettype none

package svm_pkg;

    localparam int N_CLASSES  = 6;
    localparam int N_FEATURES = 34;

    function automatic int n_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        COLLECT = 3'd2,
        ARGMAX  = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ovo_vote_collector_if.sv
// ============================================================================
// Module   : ovo_vote_collector_if
// Brief    : Start/SVM handshake and pair/result bus of the OvO vote collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ovo_vote_collector_if #(
    parameter int N_CLASSES = svm_pkg::N_CLASSES
);
    localparam int N_PAIRS = (N_CLASSES * (N_CLASSES - 1)) / 2;
    localparam int PAIR_W  = $clog2(N_PAIRS);
    localparam int CLS_W   = $clog2(N_CLASSES);

    logic              start;
    logic              svm_class;
    logic              svm_ready;
    logic [PAIR_W-1:0] pair_idx;
    logic [CLS_W-1:0]  pair_i;
    logic [CLS_W-1:0]  pair_j;
    logic              busy;
    logic [CLS_W-1:0]  class_out;
    logic              valid;

    modport master (
        output start, svm_class, svm_ready,
        input  pair_idx, pair_i, pair_j, busy, class_out, valid
    );

    modport slave (
        input  start, svm_class, svm_ready,
        output pair_idx, pair_i, pair_j, busy, class_out, valid
    );

endinterface

`default_nettype wire

// File: rtl/ovo_vote_collector_argmax.sv
// ============================================================================
// Module   : vote_argmax
// Brief    : Sequential argmax over packed vote counters, one counter per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vote_argmax
    import svm_pkg::*;
#(
    parameter int N_CLASSES = svm_pkg::N_CLASSES,
    parameter int VOTE_W    = $clog2(N_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CLASSES*VOTE_W-1:0]   votes,
    input  logic                          start_scan,
    output logic [$clog2(N_CLASSES)-1:0]  best_idx,
    output logic                          done
);
    localparam int                IDX_W = $clog2(N_CLASSES);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_CLASSES - 1);

    logic              r_active;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_best;
    logic [VOTE_W-1:0] r_best_val;

    logic [VOTE_W-1:0] w_votes [N_CLASSES];
    logic [VOTE_W-1:0] w_cur;
    logic              w_better;

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_unpack
        assign w_votes[g] = votes[g*VOTE_W +: VOTE_W];
    end

    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_cur    = w_votes[r_idx];
    assign w_better = (w_cur > r_best_val);
    assign best_idx = w_better ? r_idx : r_best;
    assign done     = r_active && (r_idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_val <= '0;
        end else if (start_scan) begin
            r_active   <= 1'b1;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_val <= '0;
        end else if (r_active) begin
            if (w_better) begin
                r_best     <= r_idx;
                r_best_val <= w_cur;
            end
            if (done) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ovo_vote_collector.sv
// ============================================================================
// Module   : ovo_vote_collector
// Brief    : Steps the shared binary SVM through all OvO pairs, tallies votes, emits argmax.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ovo_vote_collector
    import svm_pkg::*;
#(
    parameter int N_CLASSES = svm_pkg::N_CLASSES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ovo_vote_collector_if.slave  bus
);
    localparam int N_PAIRS = n_pairs(N_CLASSES);
    localparam int PAIR_W  = $clog2(N_PAIRS);
    localparam int CLS_W   = $clog2(N_CLASSES);
    localparam int VOTE_W  = $clog2(N_CLASSES);

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_SYNC    = 3'(SYNC);
    localparam logic [2:0] ST_COLLECT = 3'(COLLECT);
    localparam logic [2:0] ST_ARGMAX  = 3'(ARGMAX);
    localparam logic [2:0] ST_DONE    = 3'(DONE);

    localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(N_PAIRS - 1);
    localparam logic [CLS_W-1:0]  LAST_CLASS = CLS_W'(N_CLASSES - 1);

    logic [2:0]        r_state;
    logic [PAIR_W-1:0] r_pair_idx;
    logic [CLS_W-1:0]  r_pair_i;
    logic [CLS_W-1:0]  r_pair_j;
    logic [CLS_W-1:0]  r_class;
    logic              r_valid;
    logic [VOTE_W-1:0] r_votes [N_CLASSES];

    logic [N_CLASSES*VOTE_W-1:0] w_votes_flat;
    logic                        w_accept;
    logic                        w_last_pair;
    logic                        w_scan_start;
    logic                        w_scan_done;
    logic [CLS_W-1:0]            w_best;
    logic [CLS_W-1:0]            w_vote_cls;

    assign w_accept     = (r_state == ST_COLLECT) && bus.svm_ready;
    assign w_last_pair  = (r_pair_idx == LAST_PAIR);
    assign w_scan_start = w_accept && w_last_pair;
    assign w_vote_cls   = bus.svm_class ? r_pair_j : r_pair_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pair_idx <= '0;
            r_pair_i   <= '0;
            r_pair_j   <= CLS_W'(1);
            r_class    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_SYNC;
                        r_pair_idx <= '0;
                        r_pair_i   <= '0;
                        r_pair_j   <= CLS_W'(1);
                    end
                end
                // The frame in flight used stale weights; drop it and keep pair 0.
                ST_SYNC: begin
                    if (bus.svm_ready) begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.svm_ready) begin
                        if (w_last_pair) begin
                            r_state    <= ST_ARGMAX;
                            r_pair_idx <= '0;
                            r_pair_i   <= '0;
                            r_pair_j   <= CLS_W'(1);
                        end else begin
                            r_pair_idx <= r_pair_idx + 1'b1;
                            if (r_pair_j == LAST_CLASS) begin
                                r_pair_i <= r_pair_i + 1'b1;
                                r_pair_j <= r_pair_i + CLS_W'(2);
                            end else begin
                                r_pair_j <= r_pair_j + 1'b1;
                            end
                        end
                    end
                end
                ST_ARGMAX: begin
                    if (w_scan_done) begin
                        r_class <= w_best;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Counters never exceed N_CLASSES-1, so no saturation is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CLASSES; c++) begin
                r_votes[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CLASSES; c++) begin
                if ((r_state == ST_IDLE) && bus.start) begin
                    r_votes[c] <= '0;
                end else if (w_accept && (w_vote_cls == CLS_W'(c))) begin
                    r_votes[c] <= r_votes[c] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_flatten
        assign w_votes_flat[g*VOTE_W +: VOTE_W] = r_votes[g];
    end

    vote_argmax #(
        .N_CLASSES (N_CLASSES),
        .VOTE_W    (VOTE_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .votes      (w_votes_flat),
        .start_scan (w_scan_start),
        .best_idx   (w_best),
        .done       (w_scan_done)
    );

    assign bus.pair_idx  = r_pair_idx;
    assign bus.pair_i    = r_pair_i;
    assign bus.pair_j    = r_pair_j;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.class_out = r_class;
    assign bus.valid     = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_ovo_vote_collector.sv
// ============================================================================
// Module   : tb_ovo_vote_collector
// Brief    : Free-running SVM frame model driving the collector; votes checked against a tally model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ovo_vote_collector;
    import svm_pkg::*;

    localparam int NC    = 6;
    localparam int FRAME = N_FEATURES + 1;
    localparam int NP    = NC * (NC - 1) / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ovo_vote_collector_if #(.N_CLASSES(NC)) bus ();

    ovo_vote_collector #(.N_CLASSES(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int phase  = 0;
    int exp_i [NP];
    int exp_j [NP];
    // beats[c] bit x set: class c wins against class x (gives 2 and 4 four votes each)
    logic [5:0] beats [6] = '{6'b001000, 6'b100001, 6'b101011,
                              6'b100010, 6'b001111, 6'b010001};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        phase = (phase + 1) % FRAME;
        bus.svm_ready = (phase == FRAME - 1);
        bus.svm_class = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pair_idx"},  bus.pair_idx,  0);
        check({tag, "_pair_i"},    bus.pair_i,    0);
        check({tag, "_pair_j"},    bus.pair_j,    1);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_valid"},     bus.valid,     0);
        check({tag, "_class_out"}, bus.class_out, 0);
    endtask

    // mode: 0 all class-i wins, 1 all class-j wins, 2 random, 3 tie table
    task automatic run(input int mode, input bit poke, input bit rst7, input string tag);
        int v [NC];
        int k      = 0;
        int t_last = -100;
        int best   = 0;
        int extra  = 0;
        bit synced = 1'b0;
        bit seen   = 1'b0;
        bit poked  = 1'b0;
        bit b;
        foreach (v[c]) v[c] = 0;
        repeat ($urandom_range(0, 40)) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_rise"}, bus.busy, 1);
        for (int n = 0; n < 900 && !seen; n++) begin
            if (rst7 && k == 7) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_midrst"});
                tick();
                rst_n = 1'b1;
                repeat (3) begin
                    tick();
                    check({tag, "_no_valid_after_rst"}, bus.valid, 0);
                end
                return;
            end
            if (bus.valid) begin
                seen = 1'b1;
            end else begin
                if (bus.svm_ready) begin
                    if (!synced) begin
                        synced = 1'b1;
                    end else if (k < NP) begin
                        check($sformatf("%s_pair_idx_%0d", tag, k), bus.pair_idx, k);
                        check($sformatf("%s_pair_i_%0d", tag, k), bus.pair_i, exp_i[k]);
                        check($sformatf("%s_pair_j_%0d", tag, k), bus.pair_j, exp_j[k]);
                        case (mode)
                            0:       b = 1'b0;
                            1:       b = 1'b1;
                            3:       b = beats[exp_j[k]][exp_i[k]];
                            default: b = 1'($urandom);
                        endcase
                        bus.svm_class = b;
                        if (b) v[exp_j[k]]++;
                        else   v[exp_i[k]]++;
                        k++;
                        if (k == NP) t_last = cyc;
                    end
                end
                if (poke && !poked && synced && k == 5) begin
                    bus.start = 1'b1;
                    poked = 1'b1;
                end
                tick();
                bus.start = 1'b0;
            end
        end
        check({tag, "_valid_seen"}, seen, 1);
        if (!seen) return;
        for (int c = 1; c < NC; c++) begin
            if (v[c] > v[best]) best = c;
        end
        check({tag, "_latency"}, cyc, t_last + NC + 1);
        check({tag, "_class_out"}, bus.class_out, best);
        if (poke) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_valid_pulse"}, bus.valid, 0);
        check({tag, "_busy_fall"}, bus.busy, 0);
        check({tag, "_class_hold"}, bus.class_out, best);
        repeat (4) begin
            tick();
            if (bus.valid || bus.busy) extra++;
        end
        check({tag, "_no_restart"}, extra, 0);
    endtask

    initial begin
        int k = 0;
        bus.start     = 1'b0;
        bus.svm_class = 1'b0;
        bus.svm_ready = 1'b0;
        for (int i = 0; i < NC; i++) begin
            for (int j = i + 1; j < NC; j++) begin
                exp_i[k] = i;
                exp_j[k] = j;
                k++;
            end
        end
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle");

        run(0, 1'b0, 1'b0, "zeros");
        run(1, 1'b0, 1'b0, "ones");
        run(3, 1'b0, 1'b0, "tie");
        run(2, 1'b1, 1'b0, "busy_poke");
        run(2, 1'b0, 1'b1, "rst7");
        run(2, 1'b0, 1'b0, "after_rst");
        for (int r = 0; r < 4; r++) begin
            run(2, 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
